// File: rtl/sonar_sweep_scheduler.sv
// Sonar sweep sequencer: steps the servo position, waits to settle, launches one
// measurement per position and forwards valid results to the serial transmitter.
module sonar_sweep_scheduler #(
  parameter int unsigned N_POS          = 8,
  parameter int unsigned POS_W          = 3,
  parameter int unsigned SETTLE_CYCLES  = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 150_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ligar,
  input  logic             parar,
  input  logic             silencio,
  input  logic             medida_pronto,
  input  logic             envio_pronto,
  output logic [POS_W-1:0] posicao,
  output logic             medir,
  output logic             transmitir,
  output logic             fim_posicao,
  output logic             db_timeout,
  output logic             direcao,
  output logic             ocupado,
  output logic [3:0]       db_estado
);

  localparam int unsigned MAX_CNT = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES
                                                                     : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  // Settle spends exactly SETTLE_CYCLES in ASSENTA; the measurement wait gets one
  // extra cycle so that a result arriving on the expiry cycle still wins.
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [POS_W-1:0] POS_LAST     = POS_W'(N_POS - 1);
  localparam logic [POS_W-1:0] POS_PEN      = POS_W'(N_POS - 2);

  typedef enum logic [3:0] {
    StInicial       = 4'd0,
    StAssenta       = 4'd1,
    StMede          = 4'd2,
    StAguardaMedida = 4'd3,
    StDecide        = 4'd4,
    StTransmite     = 4'd5,
    StAguardaEnvio  = 4'd6,
    StProxima       = 4'd7
  } state_t;

  state_t             r_state, w_state_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic               r_stop, w_stop_d;
  logic [POS_W-1:0]   r_posicao, w_posicao_d;
  logic               r_direcao, w_direcao_d;
  logic               r_db_timeout, w_db_timeout_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= StInicial;
      r_cnt        <= '0;
      r_stop       <= 1'b0;
      r_posicao    <= '0;
      r_direcao    <= 1'b1;
      r_db_timeout <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_stop       <= w_stop_d;
      r_posicao    <= w_posicao_d;
      r_direcao    <= w_direcao_d;
      r_db_timeout <= w_db_timeout_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_stop_d       = r_stop;
    w_posicao_d    = r_posicao;
    w_direcao_d    = r_direcao;
    w_db_timeout_d = r_db_timeout;

    case (r_state)
      StInicial: begin
        if (ligar) begin
          w_state_d = StAssenta;
          w_cnt_d   = SETTLE_LOAD;
        end
      end
      StAssenta: begin
        if (r_cnt == '0) w_state_d = StMede;
        else             w_cnt_d   = r_cnt - CNT_W'(1);
      end
      StMede: begin
        w_state_d = StAguardaMedida;
        w_cnt_d   = TIMEOUT_LOAD;
      end
      StAguardaMedida: begin
        if (medida_pronto) begin
          w_state_d = StDecide;
        end else if (r_cnt == '0) begin
          w_state_d      = StProxima;
          w_db_timeout_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      StDecide:       w_state_d = silencio ? StProxima : StTransmite;
      StTransmite:    w_state_d = StAguardaEnvio;
      StAguardaEnvio: if (envio_pronto) w_state_d = StProxima;
      StProxima: begin
        if (r_stop || parar || !ligar) begin
          w_state_d = StInicial;
        end else begin
          w_state_d = StAssenta;
          w_cnt_d   = SETTLE_LOAD;
          // Bounce: each endpoint is visited once, direction flips on the same update.
          if (r_direcao) begin
            if (r_posicao == POS_LAST) begin
              w_direcao_d = 1'b0;
              w_posicao_d = POS_PEN;
            end else begin
              w_posicao_d = r_posicao + POS_W'(1);
            end
          end else if (r_posicao == '0) begin
            w_direcao_d = 1'b1;
            w_posicao_d = POS_W'(1);
          end else begin
            w_posicao_d = r_posicao - POS_W'(1);
          end
        end
      end
      default: w_state_d = StInicial;
    endcase

    if (w_state_d == StMede) w_db_timeout_d = 1'b0;

    if (w_state_d == StInicial)               w_stop_d = 1'b0;
    else if (parar && r_state != StInicial)   w_stop_d = 1'b1;
  end

  assign posicao     = r_posicao;
  assign direcao     = r_direcao;
  assign db_timeout  = r_db_timeout;
  assign medir       = (r_state == StMede);
  assign transmitir  = (r_state == StTransmite);
  assign fim_posicao = (r_state == StProxima);
  assign ocupado     = (r_state != StInicial);
  assign db_estado   = r_state;

endmodule

// File: tb/tb_sonar_sweep_scheduler.sv
// Scoreboard bench for sonar_sweep_scheduler: stimulus queues expected output events,
// a monitor pops and compares them as the DUT pulses its outputs.
module tb_sonar_sweep_scheduler;

  localparam int unsigned NP = 4;
  localparam int unsigned PW = 2;
  localparam int unsigned ST = 4;
  localparam int unsigned TO = 10;

  localparam int EvMedir = 0;
  localparam int EvTx    = 1;
  localparam int EvTmo   = 2;
  localparam int EvFim   = 3;

  typedef struct {
    int kind;
    int cyc;
    int pos;
    int dir;
  } evt_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ligar = 1'b0;
  logic          parar = 1'b0;
  logic          silencio = 1'b0;
  logic          medida_pronto = 1'b0;
  logic          envio_pronto = 1'b0;
  logic [PW-1:0] posicao;
  logic          medir, transmitir, fim_posicao, db_timeout, direcao, ocupado;
  logic [3:0]    db_estado;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   med_lat = 3;
  int   env_lat = 5;
  evt_t exp_q[$];

  sonar_sweep_scheduler #(
    .N_POS         (NP),
    .POS_W         (PW),
    .SETTLE_CYCLES (ST),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ligar        (ligar),
    .parar        (parar),
    .silencio     (silencio),
    .medida_pronto(medida_pronto),
    .envio_pronto (envio_pronto),
    .posicao      (posicao),
    .medir        (medir),
    .transmitir   (transmitir),
    .fim_posicao  (fim_posicao),
    .db_timeout   (db_timeout),
    .direcao      (direcao),
    .ocupado      (ocupado),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int snap();
    return int'({db_estado, posicao, medir, transmitir, fim_posicao, db_timeout, direcao,
                 ocupado});
  endfunction

  function automatic int idle(input logic [PW-1:0] p, input logic d);
    return int'({4'd0, p, 4'b0000, d, 1'b0});
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int pos, input int dir);
    evt_t e;
    e.kind = kind;
    e.cyc  = c;
    e.pos  = pos;
    e.dir  = dir;
    exp_q.push_back(e);
  endtask

  // Measurement answered 3 cycles after medir, transmission 5 cycles after transmitir.
  task automatic push_normal(input int m, input int pos, input int dir);
    push(EvMedir, m, pos, dir);
    push(EvTx, m + 5, pos, dir);
    push(EvFim, m + 11, pos, dir);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic check_evt(input int kind);
    evt_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL event_unexpected: got kind=%0d cyc=%0d pos=%0d dir=%0d, want none",
               kind, cyc, posicao, direcao);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.pos != int'(posicao) || e.dir != int'(direcao))
      begin
        n_err++;
        $display("FAIL event: got kind=%0d cyc=%0d pos=%0d dir=%0d, want kind=%0d cyc=%0d pos=%0d dir=%0d",
                 kind, cyc, posicao, direcao, e.kind, e.cyc, e.pos, e.dir);
      end
    end
  endtask

  // Emulates the measurement datapath and transmitter handshakes.
  initial begin : responder
    int med_cnt;
    int env_cnt;
    med_cnt = 0;
    env_cnt = 0;
    forever begin
      @(negedge clock);
      medida_pronto = 1'b0;
      envio_pronto  = 1'b0;
      if (!reset) begin
        med_cnt = 0;
        env_cnt = 0;
      end else begin
        if (med_cnt > 0) begin
          med_cnt--;
          if (med_cnt == 0) medida_pronto = 1'b1;
        end
        if (env_cnt > 0) begin
          env_cnt--;
          if (env_cnt == 0) envio_pronto = 1'b1;
        end
        if (medir && med_lat > 0)    med_cnt = med_lat;
        if (transmitir && env_lat > 0) env_cnt = env_lat;
      end
    end
  end

  initial begin : monitor
    logic tmo_prev;
    tmo_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (medir) begin
        check_evt(EvMedir);
        chk("timeout_clear_at_medir", int'(db_timeout), 0);
      end
      if (transmitir)               check_evt(EvTx);
      if (db_timeout && !tmo_prev)  check_evt(EvTmo);
      if (fim_posicao)              check_evt(EvFim);
      tmo_prev = db_timeout;
    end
  end

  initial begin : stimulus
    int m, ma, mb, mc, md, me, m5, m6, m7, m8;
    int seq_pos[8];
    int seq_dir[8];
    seq_pos = '{0, 1, 2, 3, 2, 1, 0, 1};
    seq_dir = '{1, 1, 1, 1, 0, 0, 0, 1};

    repeat (3) @(negedge clock);
    chk("reset_held", snap(), idle(2'd0, 1'b1));
    reset = 1'b1;
    repeat (20) @(negedge clock);
    chk("idle_after_reset", snap(), idle(2'd0, 1'b1));

    // Eight-position bounce sweep, stopped by dropping ligar.
    m = cyc + 5;
    for (int i = 0; i < 8; i++) push_normal(m + 16 * i, seq_pos[i], seq_dir[i]);
    ligar = 1'b1;
    wait_cyc(m + 7 * 16 + 2);
    ligar = 1'b0;
    wait_cyc(m + 7 * 16 + 14);
    chk("stop_on_ligar_low", snap(), idle(2'd1, 1'b1));

    // Restart at retained position: timeout, expiry-cycle answer, silence, then parar.
    med_lat = 0;
    ma = cyc + 5;
    mb = ma + 17;
    mc = mb + 24;
    md = mc + 10;
    me = md + 10;
    push(EvMedir, ma, 1, 1);
    push(EvTmo, ma + 12, 1, 1);
    push(EvFim, ma + 12, 1, 1);
    push(EvMedir, mb, 2, 1);
    push(EvTx, mb + 13, 2, 1);
    push(EvFim, mb + 19, 2, 1);
    push(EvMedir, mc, 3, 1);
    push(EvFim, mc + 5, 3, 1);
    push(EvMedir, md, 2, 0);
    push(EvFim, md + 5, 2, 0);
    push_normal(me, 1, 0);
    ligar = 1'b1;
    wait_cyc(ma + 14);
    med_lat = 11;
    wait_cyc(mb + 20);
    med_lat  = 3;
    silencio = 1'b1;
    wait_cyc(md + 6);
    silencio = 1'b0;
    wait_cyc(me + 7);
    parar = 1'b1;
    @(negedge clock);
    parar = 1'b0;
    wait_cyc(me + 12);
    ligar = 1'b0;
    wait_cyc(me + 14);
    chk("stop_on_parar", snap(), idle(2'd1, 1'b0));

    // Re-ligar measures the held position first; then reset while waiting at position 2.
    m5 = cyc + 5;
    m6 = m5 + 16;
    m7 = m6 + 16;
    m8 = m7 + 16;
    push_normal(m5, 1, 0);
    push_normal(m6, 0, 0);
    push_normal(m7, 1, 1);
    push(EvMedir, m8, 2, 1);
    ligar = 1'b1;
    wait_cyc(m8 + 2);
    chk("pre_reset_state", int'(db_estado), 3);
    reset = 1'b0;
    ligar = 1'b0;
    #1;
    chk("async_reset", snap(), idle(2'd0, 1'b1));
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    chk("idle_after_release", snap(), idle(2'd0, 1'b1));

    while (exp_q.size() > 0) begin
      evt_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL event_missing: got none, want kind=%0d cyc=%0d pos=%0d dir=%0d",
               e.kind, e.cyc, e.pos, e.dir);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
